regfile_port_arbiter: RTL

REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

---
 rtl/regfile_port_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_port_arbiter
//  Purpose  : Round-robin arbiter sharing one register-file read port among
//             NREQ requesters, with a two-stage read pipeline and forwarding.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_port_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     hold,
    output logic [ADDR_W-1:0]        rf_sel,
    input  logic [DATA_W-1:0]        rf_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0]  own_a_q, own_a_d;
    logic              vld_a_q, vld_a_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic              w_accept;
    logic [IDX_W-1:0]  w_win;
    logic [IDX_W:0]    w_sum;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd_data;

    // Search upward from rr_ptr, wrapping modulo NREQ; first valid wins.
    always_comb begin
        w_accept = 1'b0;
        w_win    = '0;
        w_sum    = '0;
        w_idx    = '0;
        if (!hold) begin
            for (int k = 0; k < NREQ; k++) begin
                w_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
                if (w_sum >= (IDX_W+1)'(NREQ)) begin
                    w_sum = w_sum - (IDX_W+1)'(NREQ);
                end
                w_idx = w_sum[IDX_W-1:0];
                if (!w_accept && req_valid[w_idx]) begin
                    w_accept = 1'b1;
                    w_win    = w_idx;
                end
            end
        end
        req_ready = w_accept ? (NREQ'(1) << w_win) : '0;
    end

    // x0 always reads zero; a same-cycle write to the selected register wins over the mux.
    always_comb begin
        if (sel_q == '0) begin
            w_rd_data = '0;
        end else if (wr_en && (wr_addr == sel_q)) begin
            w_rd_data = wr_data;
        end else begin
            w_rd_data = rf_data;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        sel_d       = sel_q;
        own_a_d     = own_a_q;
        vld_a_d     = vld_a_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (!hold) begin
            vld_a_d = w_accept;
            if (w_accept) begin
                sel_d    = req_addr[w_win*ADDR_W +: ADDR_W];
                own_a_d  = w_win;
                rr_ptr_d = (w_win == IDX_W'(NREQ-1)) ? '0 : w_win + 1'b1;
            end
            rsp_valid_d = vld_a_q ? (NREQ'(1) << own_a_q) : '0;
            rsp_data_d  = w_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            sel_q       <= '0;
            own_a_q     <= '0;
            vld_a_q     <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            sel_q       <= sel_d;
            own_a_q     <= own_a_d;
            vld_a_q     <= vld_a_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rf_sel    = sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = vld_a_q | (|rsp_valid_q);

endmodule
`default_nettype wire
